period_to_freq: RTL and testbench

Converts the measured period (clock cycles between two rising edges of the input signal) into a frequency in Hz: freq = CLK_HZ / period. Sits directly downstream of the period-capture stage in the frequency-meter datapath and feeds the display/BCD stage. Uses an iterative restoring divider, one quotient bit per clock, and recomputes only when the incoming period value changes.

---
 rtl/period_to_freq.sv | 113 +++++++++++
 tb/tb_period_to_freq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/period_to_freq.sv
// Period-to-frequency converter: freq = CLK_HZ / period via an iterative restoring divider.
// Define PERIOD_TO_FREQ_ROUND_EN for round-to-nearest; otherwise the result is truncated.
module period_to_freq #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned PW     = 24,
  parameter int unsigned FW     = 27
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] period,
  output logic [FW-1:0] freq,
  output logic          freq_valid,
  output logic          busy
);

  localparam int unsigned RW = PW + 1;
  localparam int unsigned SW = PW + 2;
  localparam int unsigned CW = $clog2(FW + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_last_period;
  logic [PW-1:0] r_divisor;
  logic [FW-1:0] r_dividend;
  logic [RW-1:0] r_rem;
  logic [FW-1:0] r_quot;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_freq;
  logic          r_freq_valid;
  logic          r_busy;

  logic          w_start;
  logic [FW-1:0] w_dividend_init;
  logic [SW-1:0] w_shift;
  logic          w_ge;
  logic [RW-1:0] w_rem_next;

  assign w_start = (r_state == IDLE) && (period != '0) && (period != r_last_period);

`ifdef PERIOD_TO_FREQ_ROUND_EN
  assign w_dividend_init = FW'(CLK_HZ) + FW'(period >> 1);
`else
  assign w_dividend_init = FW'(CLK_HZ);
`endif

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign w_shift    = {r_rem, r_dividend[FW-1]};
  assign w_ge       = (w_shift >= SW'(r_divisor));
  assign w_rem_next = w_ge ? RW'(w_shift - SW'(r_divisor)) : w_shift[RW-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = DIV;
      DIV:     if (r_cnt == CW'(1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_period <= '0;
      r_divisor     <= '0;
      r_dividend    <= '0;
      r_rem         <= '0;
      r_quot        <= '0;
      r_cnt         <= '0;
      r_freq        <= '0;
      r_freq_valid  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_last_period <= period;
            r_divisor     <= period;
            r_dividend    <= w_dividend_init;
            r_rem         <= '0;
            r_quot        <= '0;
            r_cnt         <= CW'(FW);
            r_busy        <= 1'b1;
          end
        end
        DIV: begin
          r_rem      <= w_rem_next;
          r_quot     <= {r_quot[FW-2:0], w_ge};
          r_dividend <= {r_dividend[FW-2:0], 1'b0};
          r_cnt      <= r_cnt - CW'(1);
        end
        DONE: begin
          r_freq       <= r_quot;
          r_freq_valid <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign freq       = r_freq;
  assign freq_valid = r_freq_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_period_to_freq.sv
// Scoreboard bench for period_to_freq: stimulus pushes expected (freq, pulse cycle), monitor pops on freq_valid.
module tb_period_to_freq;

  localparam int unsigned PW  = 24;
  localparam int unsigned FW  = 27;
  localparam int          LAT = 28;

  typedef struct {
    longint freq;
    int     cyc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [PW-1:0] period;
  logic [FW-1:0] freq;
  logic          freq_valid;
  logic          busy;

  exp_t q[$];
  int   cyc;
  int   pulses;
  int   n_checks;
  int   n_pass;

  period_to_freq #(.CLK_HZ(50_000_000), .PW(PW), .FW(FW)) dut (
    .clk        (clk),
    .reset      (reset),
    .period     (period),
    .freq       (freq),
    .freq_valid (freq_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every freq_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (freq_valid === 1'b1) begin
      exp_t e;
      pulses++;
      if (q.size() == 0) begin
        chk("unexpected_freq_valid", longint'(freq), -1);
      end else begin
        e = q.pop_front();
        chk("freq", longint'(freq), e.freq);
        if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
        chk("busy_low_at_valid", longint'(busy), 0);
      end
    end
  end

  // Drive period at a negedge; the following posedge is the start edge.
  task automatic issue(input int p, input longint f);
    exp_t e;
    @(negedge clk);
    period = PW'(p);
    e.freq = f;
    e.cyc  = cyc + 1 + LAT;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= 300) begin
      chk({name, "_timeout_pending"}, q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    int pc;
    exp_t e;
    n_checks = 0;
    n_pass   = 0;
    pulses   = 0;
    reset    = 1'b1;
    period   = '0;
    repeat (3) @(negedge clk);
    chk("reset_freq", longint'(freq), 0);
    chk("reset_valid", longint'(freq_valid), 0);
    chk("reset_busy", longint'(busy), 0);
    reset = 1'b0;

    // period == 0 never starts a division
    repeat (100) @(negedge clk);
    chk("zero_period_pulses", pulses, 0);
    chk("zero_period_busy", longint'(busy), 0);
    chk("zero_period_freq", longint'(freq), 0);

    issue(50_000, 1000);
    @(posedge clk);
    #1;
    chk("busy_on_start", longint'(busy), 1);
    drain("p50000");
    pc = pulses;
    repeat (80) @(negedge clk);
    chk("held_period_no_retrigger", pulses, pc);
    chk("held_freq", longint'(freq), 1000);

`ifdef PERIOD_TO_FREQ_ROUND_EN
    issue(30_000, 1667);
    drain("p30000");
    issue(3, 16_666_667);
    drain("p3");
`else
    issue(30_000, 1666);
    drain("p30000");
    issue(3, 16_666_666);
    drain("p3");
`endif
    issue(1, 50_000_000);
    drain("p1");
    issue(7, 7_142_857);
    drain("p7");

    // Change mid-division: second result follows FW+2 cycles after the first.
    issue(50_000, 1000);
    e.cyc = q[0].cyc + FW + 2;
    e.freq = 2000;
    repeat (10) @(negedge clk);
    period = PW'(25_000);
    q.push_back(e);
    drain("midchange");

    // Reset 5 cycles into a division aborts it and clears last_period.
    @(negedge clk);
    period = PW'(40_000);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_freq", longint'(freq), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_valid", longint'(freq_valid), 0);
    pc = pulses;
    e.freq = 1250;
    e.cyc  = cyc + 1 + LAT;
    reset = 1'b0;
    q.push_back(e);
    drain("after_abort");
    chk("after_abort_pulses", pulses, pc + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
